// File: rtl/sha2_msg_feeder_pkg.sv
// rtl/sha2_msg_feeder_pkg.sv - shared constants and FSM encoding for the SHA-2 message feeder
package sha2_msg_feeder_pkg;

  localparam int MAX_K_256 = 64;
  localparam int MAX_K_512 = 80;
  localparam int BLK_WORDS = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_FILL,
    ST_PAD,
    ST_LEN,
    ST_LOAD,
    ST_HASH,
    ST_SAVE,
    ST_DONE
  } state_e;

  function automatic int max_k(input int mode);
    return (mode == 384 || mode == 512) ? MAX_K_512 : MAX_K_256;
  endfunction

endpackage

// File: rtl/sha2_msg_feeder_pad_word.sv
// rtl/sha2_msg_feeder_pad_word.sv - keeps the leading nbytes of a word, inserts 0x80 after them
module sha2_msg_feeder_pad_word #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0]           data,
  input  logic [$clog2(WIDTH/8):0]   nbytes,
  output logic [WIDTH-1:0]           padded
);

  localparam int NB = WIDTH / 8;

  // byte 0 is the MSB byte; nbytes >= NB leaves the word intact
  always_comb begin
    padded = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < int'(nbytes)) begin
        padded[WIDTH-1-8*i -: 8] = data[WIDTH-1-8*i -: 8];
      end else if (i == int'(nbytes)) begin
        padded[WIDTH-1-8*i -: 8] = 8'h80;
      end
    end
  end

endmodule

// File: rtl/sha2_msg_feeder.sv
// rtl/sha2_msg_feeder.sv - pads a word stream into SHA-2 blocks and sequences sha2_core per block
module sha2_msg_feeder
  import sha2_msg_feeder_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int MODE  = 512
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       msg_valid,
  output logic                       msg_ready,
  input  logic [WIDTH-1:0]           msg_data,
  input  logic                       msg_last,
  input  logic [$clog2(WIDTH/8):0]   msg_bytes,
  output logic                       busy,
  output logic                       digest_valid,
  output logic [8*WIDTH-1:0]         digest,
  output logic                       core_rst_n,
  output logic                       core_load,
  output logic                       core_start,
  output logic [WIDTH-1:0]           core_data,
  input  logic                       core_end_op,
  input  logic [8*WIDTH-1:0]         core_h_out
);

  localparam int              BW    = $clog2(WIDTH / 8);
  localparam logic [BW:0]     NB_W  = (BW + 1)'(WIDTH / 8);
  localparam logic [WIDTH-1:0] PAD80 = {8'h80, {(WIDTH - 8){1'b0}}};
  localparam int              MAX_K = max_k(MODE);

  // MODE only sets the core's round count; the feeder simply waits for core_end_op
  logic unused_mode;
  assign unused_mode = (MAX_K == MAX_K_512);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      blk_q [BLK_WORDS];
  logic [WIDTH-1:0]      blk_d [BLK_WORDS];
  logic [3:0]            widx_q, widx_d;
  logic [63:0]           bitcnt_q, bitcnt_d;
  logic                  last_q, last_d;
  logic                  pend80_q, pend80_d;
  logic                  final_q, final_d;
  logic [8*WIDTH-1:0]    digest_q, digest_d;

  logic                  accept;
  logic [BW:0]           bytes_c;
  logic [BW:0]           word_bytes;
  logic [WIDTH-1:0]      last_word;
  logic [2*WIDTH-1:0]    len_bits;
  logic                  pad_to_len;

  assign accept     = (state_q == ST_FILL) && msg_valid;
  assign bytes_c    = (msg_bytes > NB_W) ? NB_W : msg_bytes;
  assign word_bytes = msg_last ? bytes_c : NB_W;
  assign len_bits   = (2 * WIDTH)'(bitcnt_q);
  assign pad_to_len = (widx_q == 4'd14) && !pend80_q;

  sha2_msg_feeder_pad_word #(.WIDTH(WIDTH)) u_pad_word (
    .data   (msg_data),
    .nbytes (bytes_c),
    .padded (last_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (msg_valid) state_d = ST_INIT;
      ST_INIT: state_d = ST_FILL;
      ST_FILL: begin
        if (accept) begin
          if (widx_q == 4'd15)   state_d = ST_LOAD;
          else if (msg_last)     state_d = ST_PAD;
        end
      end
      ST_PAD: begin
        if (pad_to_len)            state_d = ST_LEN;
        else if (widx_q == 4'd15)  state_d = ST_LOAD;
      end
      ST_LEN:  state_d = ST_LOAD;
      ST_LOAD: if (widx_q == 4'd15) state_d = ST_HASH;
      ST_HASH: if (core_end_op) state_d = ST_SAVE;
      ST_SAVE: state_d = final_q ? ST_DONE : (last_q ? ST_PAD : ST_FILL);
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    msg_ready    = (state_q == ST_FILL);
    busy         = state_q inside {ST_FILL, ST_PAD, ST_LEN, ST_LOAD, ST_HASH, ST_SAVE};
    digest_valid = (state_q == ST_DONE);
    core_rst_n   = !(state_q inside {ST_IDLE, ST_INIT});
    core_load    = (state_q == ST_LOAD);
    core_start   = (state_q == ST_HASH) && !core_end_op;
    core_data    = (state_q == ST_LOAD) ? blk_q[widx_q] : '0;
  end

  assign digest = digest_q;

  // widx doubles as the LOAD read pointer; every path into LOAD leaves it at 0
  always_comb begin
    blk_d    = blk_q;
    widx_d   = widx_q;
    bitcnt_d = bitcnt_q;
    last_d   = last_q;
    pend80_d = pend80_q;
    final_d  = final_q;
    digest_d = digest_q;
    case (state_q)
      ST_INIT: begin
        widx_d   = '0;
        bitcnt_d = '0;
        last_d   = 1'b0;
        pend80_d = 1'b0;
        final_d  = 1'b0;
      end
      ST_FILL: begin
        if (accept) begin
          blk_d[widx_q] = msg_last ? last_word : msg_data;
          widx_d        = widx_q + 4'd1;
          bitcnt_d      = bitcnt_q + {{(64 - BW - 4){1'b0}}, word_bytes, 3'b000};
          last_d        = msg_last;
          pend80_d      = msg_last && (bytes_c == NB_W);
        end
      end
      ST_PAD: begin
        if (!pad_to_len) begin
          blk_d[widx_q] = pend80_q ? PAD80 : '0;
          pend80_d      = 1'b0;
          widx_d        = widx_q + 4'd1;
        end
      end
      ST_LEN: begin
        blk_d[14] = len_bits[2*WIDTH-1:WIDTH];
        blk_d[15] = len_bits[WIDTH-1:0];
        widx_d    = '0;
        final_d   = 1'b1;
      end
      ST_LOAD: widx_d = widx_q + 4'd1;
      ST_SAVE: begin
        widx_d = '0;
        if (final_q) digest_d = core_h_out;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BLK_WORDS; i++) blk_q[i] <= '0;
      widx_q   <= '0;
      bitcnt_q <= '0;
      last_q   <= 1'b0;
      pend80_q <= 1'b0;
      final_q  <= 1'b0;
      digest_q <= '0;
    end else begin
      blk_q    <= blk_d;
      widx_q   <= widx_d;
      bitcnt_q <= bitcnt_d;
      last_q   <= last_d;
      pend80_q <= pend80_d;
      final_q  <= final_d;
      digest_q <= digest_d;
    end
  end

endmodule

// File: tb/tb_sha2_msg_feeder.sv
// tb/tb_sha2_msg_feeder.sv - SHA-256 feeder bench with a behavioural core and byte-level padding model
module tb_sha2_msg_feeder;

  localparam int WIDTH = 32;
  localparam int WAIT_MAX = 3000;
  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [0:63][31:0] K256 = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] KAT_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] KAT_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] KAT_56 =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  typedef logic [7:0] bq_t[$];

  logic         clk, rst;
  logic         msg_valid, msg_ready, msg_last;
  logic [31:0]  msg_data;
  logic [2:0]   msg_bytes;
  logic         busy, digest_valid;
  logic [255:0] digest;
  logic         core_rst_n, core_load, core_start, core_end_op;
  logic [31:0]  core_data;
  logic [255:0] core_h_out;

  int checks = 0;
  int failures = 0;
  int gap_max = 0;
  int load_cnt = 0;
  logic aborted = 1'b0;
  logic prev_dv = 1'b0;
  logic [31:0]  exp_words[$];
  logic [255:0] exp_dig[$];
  int           exp_blk[$];

  sha2_msg_feeder #(.WIDTH(WIDTH), .MODE(256)) dut (
    .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_data(msg_data), .msg_last(msg_last), .msg_bytes(msg_bytes),
    .busy(busy), .digest_valid(digest_valid), .digest(digest),
    .core_rst_n(core_rst_n), .core_load(core_load), .core_start(core_start),
    .core_data(core_data), .core_end_op(core_end_op), .core_h_out(core_h_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha256_compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w[64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K256[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  // behavioural sha2_core: shifts in loaded words, hashes once per start, pulses end_op
  logic [511:0] mc_blk;
  logic [255:0] mc_h;
  logic         mc_run;
  int           mc_cnt;
  always @(posedge clk) begin
    core_end_op <= 1'b0;
    if (!core_rst_n) begin
      mc_h   <= IV;
      mc_run <= 1'b0;
      mc_cnt <= 0;
    end else begin
      if (core_load) mc_blk <= {mc_blk[479:0], core_data};
      if (core_start && !mc_run) begin
        mc_run <= 1'b1;
        mc_cnt <= 0;
      end else if (mc_run) begin
        mc_cnt <= mc_cnt + 1;
        if (mc_cnt == 61) begin
          mc_run      <= 1'b0;
          core_end_op <= 1'b1;
          mc_h        <= sha256_compress(mc_h, mc_blk);
        end
      end
    end
  end
  assign core_h_out = mc_h;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // padding computed on bytes: msg, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length
  task automatic model_push(input bq_t m, output logic [255:0] h);
    bq_t p;
    logic [63:0]  bl;
    logic [511:0] blk;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(m.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    for (int i = 0; i < p.size(); i += 4) exp_words.push_back({p[i], p[i+1], p[i+2], p[i+3]});
    exp_blk.push_back(p.size() / 64);
    h = IV;
    for (int bk = 0; bk < p.size() / 64; bk++) begin
      for (int i = 0; i < 64; i++) blk[511-8*i -: 8] = p[64*bk+i];
      h = sha256_compress(h, blk);
    end
  endtask

  task automatic put_word(input logic [31:0] d, input logic l, input logic [2:0] bb);
    int t;
    if (aborted) return;
    repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    msg_valid = 1'b1; msg_data = d; msg_last = l; msg_bytes = bb;
    t = 0;
    do begin @(negedge clk); t++; end while (!msg_ready && t < WAIT_MAX);
    if (!msg_ready) begin
      chk("accept_timeout", 256'(msg_ready), 256'(1));
      aborted = 1'b1;
    end
    @(posedge clk); #1;
    msg_valid = 1'b0; msg_data = $urandom; msg_last = 1'b0; msg_bytes = 3'($urandom);
  endtask

  task automatic send_msg(input bq_t m);
    int n, nw, nb;
    logic [31:0] d;
    logic [2:0]  bb;
    logic        l;
    n  = m.size();
    nw = (n == 0) ? 1 : (n + 3) / 4;
    for (int j = 0; j < nw; j++) begin
      for (int b = 0; b < 4; b++) d[31-8*b -: 8] = (4*j + b < n) ? m[4*j+b] : 8'($urandom);
      l  = (j == nw - 1);
      nb = n - 4*j;
      if (!l)          bb = 3'($urandom_range(0, 7));
      else if (nb >= 4) bb = 3'($urandom_range(4, 7));
      else             bb = 3'(nb);
      put_word(d, l, bb);
    end
  endtask

  task automatic issue(input bq_t m, input logic kat_en, input logic [255:0] kat);
    logic [255:0] h;
    model_push(m, h);
    exp_dig.push_back(kat_en ? kat : h);
    send_msg(m);
  endtask

  function automatic bq_t str_bytes(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic drain();
    int t = 0;
    while (exp_dig.size() != 0 && t < 20000) begin @(negedge clk); t++; end
    chk("drain_pending_digests", 256'(exp_dig.size()), 256'(0));
    @(posedge clk); #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_msg_ready"},    256'(msg_ready),    256'(0));
    chk({tag, "_busy"},         256'(busy),         256'(0));
    chk({tag, "_digest_valid"}, 256'(digest_valid), 256'(0));
    chk({tag, "_digest"},       digest,             256'(0));
    chk({tag, "_core_rst_n"},   256'(core_rst_n),   256'(0));
    chk({tag, "_core_load"},    256'(core_load),    256'(0));
    chk({tag, "_core_start"},   256'(core_start),   256'(0));
    chk({tag, "_core_data"},    256'(core_data),    256'(0));
  endtask

  // scoreboard monitor: every loaded word and every digest pulse is matched against the queues
  always @(negedge clk) begin
    if (rst) begin
      load_cnt = 0;
      prev_dv  = 1'b0;
    end else begin
      if (core_load) begin
        load_cnt++;
        if (exp_words.size() == 0) chk("unexpected_core_load", 256'(core_load), 256'(0));
        else chk("core_data", 256'(core_data), 256'(exp_words.pop_front()));
      end
      if (digest_valid) begin
        chk("digest_pulse_width", 256'(prev_dv), 256'(0));
        chk("busy_at_digest", 256'(busy), 256'(0));
        if (exp_dig.size() == 0) chk("unexpected_digest", 256'(digest_valid), 256'(0));
        else begin
          chk("digest", digest, exp_dig.pop_front());
          chk("load_cycles", 256'(load_cnt), 256'(16 * exp_blk.pop_front()));
        end
        load_cnt = 0;
      end
      prev_dv = digest_valid;
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation exceeded its cycle budget");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int dir_len[] = '{0, 1, 3, 4, 5, 52, 55, 56, 57, 59, 60, 61, 63, 64, 65, 119, 120, 128};
    int t;
    rst = 1'b1; msg_valid = 1'b0; msg_data = '0; msg_last = 1'b0; msg_bytes = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    issue(str_bytes("abc"), 1'b1, KAT_ABC);
    issue(str_bytes(""), 1'b1, KAT_EMPTY);
    issue(str_bytes("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"), 1'b1, KAT_56);
    drain();

    gap_max = 3;
    issue(str_bytes("abc"), 1'b1, KAT_ABC);
    issue(str_bytes("abc"), 1'b1, KAT_ABC);
    foreach (dir_len[i]) issue(rand_bytes(dir_len[i]), 1'b0, '0);
    gap_max = 0;
    for (int i = 0; i < 12; i++) begin
      gap_max = (i % 2 == 0) ? 0 : 4;
      issue(rand_bytes($urandom_range(0, 140)), 1'b0, '0);
    end
    drain();

    issue(str_bytes("abc"), 1'b0, '0);
    t = 0;
    while (!core_start && t < WAIT_MAX) begin @(negedge clk); t++; end
    chk("reach_hash", 256'(core_start), 256'(1));
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs_zero("mid_hash_reset");
    exp_words.delete();
    exp_dig.delete();
    exp_blk.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    issue(str_bytes("abc"), 1'b1, KAT_ABC);
    drain();
    chk("leftover_words", 256'(exp_words.size()), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
